a51_stream: RTL and testbench

A51_STREAM -- requirements
Module: a51_stream

---
 rtl/a51_stream.sv | 215 +++++++++++++++++++++
 tb/tb_a51_stream.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/a51_stream.sv
// A5/1 keystream generator wrapped as a valid/ready stream cipher: load key and
// frame, discard the mixing steps, then XOR DW-bit keystream words onto plaintext beats.
module a51_stream #(
    parameter int unsigned DW         = 8,
    parameter int unsigned FRAME_W    = 22,
    parameter int unsigned MIX_CYCLES = 100,
    parameter int unsigned MAX_BEATS  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [63:0]        key,
    input  logic [FRAME_W-1:0] frame,
    output logic               busy,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic               done,
    output logic [2:0]         state_dbg
);

    // Handshake: a beat moves on a port in every cycle where valid && ready are
    // both high at the rising edge; valid never depends on ready on the same port.

    // Wide enough for the full legal MIX_CYCLES range, not just the 64 key steps.
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned FILL_W = $clog2(DW + 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_KEY   = 3'd1,
        LOAD_FRAME = 3'd2,
        MIX        = 3'd3,
        RUN        = 3'd4,
        DONE       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [18:0]        r1_q, r1_d;
    logic [21:0]        r2_q, r2_d;
    logic [22:0]        r3_q, r3_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [63:0]        key_q, key_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [DW-1:0]      ks_q, ks_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        beats_q, beats_d;

    function automatic logic [18:0] step_r1(input logic [18:0] r);
        return {r[17:0], r[18] ^ r[17] ^ r[16] ^ r[13]};
    endfunction

    function automatic logic [21:0] step_r2(input logic [21:0] r);
        return {r[20:0], r[21] ^ r[20]};
    endfunction

    function automatic logic [22:0] step_r3(input logic [22:0] r);
        return {r[21:0], r[22] ^ r[21] ^ r[20] ^ r[7]};
    endfunction

    logic        maj;
    logic [18:0] r1_m, r1_l;
    logic [21:0] r2_m, r2_l;
    logic [22:0] r3_m, r3_l;
    logic        ks_bit;
    logic        load_bit;
    logic        fill_full;
    logic        accept;

    assign maj  = (r1_q[8] & r2_q[10]) | (r1_q[8] & r3_q[10]) | (r2_q[10] & r3_q[10]);
    assign r1_m = (r1_q[8]  == maj) ? step_r1(r1_q) : r1_q;
    assign r2_m = (r2_q[10] == maj) ? step_r2(r2_q) : r2_q;
    assign r3_m = (r3_q[10] == maj) ? step_r3(r3_q) : r3_q;
    assign ks_bit = r1_m[18] ^ r2_m[21] ^ r3_m[22];

    // Key and frame are consumed LSB-first from shift copies taken at start.
    assign load_bit = (state_q == LOAD_KEY) ? key_q[0] : frame_q[0];
    assign r1_l = step_r1(r1_q) ^ {18'b0, load_bit};
    assign r2_l = step_r2(r2_q) ^ {21'b0, load_bit};
    assign r3_l = step_r3(r3_q) ^ {22'b0, load_bit};

    assign fill_full = (fill_q == FILL_W'(DW));
    assign in_ready  = (state_q == RUN) && fill_full && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    assign busy      = (state_q == LOAD_KEY) || (state_q == LOAD_FRAME) || (state_q == MIX);
    assign done      = (state_q == DONE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        r3_d        = r3_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        frame_d     = frame_q;
        fill_d      = fill_q;
        ks_d        = ks_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        beats_d     = beats_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            LOAD_KEY: begin
                r1_d  = r1_l;
                r2_d  = r2_l;
                r3_d  = r3_l;
                key_d = key_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(63)) begin
                    cnt_d   = '0;
                    state_d = LOAD_FRAME;
                end
            end
            LOAD_FRAME: begin
                r1_d    = r1_l;
                r2_d    = r2_l;
                r3_d    = r3_l;
                frame_d = frame_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(FRAME_W - 1)) begin
                    cnt_d   = '0;
                    state_d = (MIX_CYCLES == 0) ? RUN : MIX;
                end
            end
            MIX: begin
                r1_d  = r1_m;
                r2_d  = r2_m;
                r3_d  = r3_m;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MIX_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!fill_full) begin
                    r1_d   = r1_m;
                    r2_d   = r2_m;
                    r3_d   = r3_m;
                    ks_d   = (ks_q << 1) | DW'(ks_bit);
                    fill_d = fill_q + FILL_W'(1);
                end
                if (accept) begin
                    out_data_d  = in_data ^ ks_q;
                    out_valid_d = 1'b1;
                    fill_d      = '0;
                    beats_d     = beats_q + 32'd1;
                    if ((MAX_BEATS != 0) && (beats_q + 32'd1 == 32'(MAX_BEATS))) begin
                        state_d = DONE;
                    end
                end
            end
            default: ;
        endcase

        // Start wins over everything, including a pending output beat.
        if (start) begin
            state_d     = LOAD_KEY;
            r1_d        = '0;
            r2_d        = '0;
            r3_d        = '0;
            cnt_d       = '0;
            key_d       = key;
            frame_d     = frame;
            fill_d      = '0;
            ks_d        = '0;
            out_valid_d = 1'b0;
            beats_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            r1_q        <= '0;
            r2_q        <= '0;
            r3_q        <= '0;
            cnt_q       <= '0;
            key_q       <= '0;
            frame_q     <= '0;
            fill_q      <= '0;
            ks_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            beats_q     <= '0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            r3_q        <= r3_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            frame_q     <= frame_d;
            fill_q      <= fill_d;
            ks_q        <= ks_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            beats_q     <= beats_d;
        end
    end

endmodule

// File: tb/tb_a51_stream.sv
// Directed bench for a51_stream: known A5/1 vector, start-to-output timing,
// backpressure, restarts, beat limit and asynchronous reset.
module tb_a51_stream;

  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [63:0]   key;
  logic [21:0]   frame;
  logic          busy;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          done;
  logic [2:0]    state_dbg;

  logic          start_l;
  logic          busy_l;
  logic          in_valid_l;
  logic          in_ready_l;
  logic          out_valid_l;
  logic          out_ready_l;
  logic [DW-1:0] out_data_l;
  logic          done_l;
  logic [2:0]    state_dbg_l;

  int tests_run;
  int failed;
  int cyc;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];

  a51_stream u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .frame     (frame),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .done      (done),
    .state_dbg (state_dbg)
  );

  a51_stream #(.MAX_BEATS(3)) u_lim (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_l),
    .key       (key),
    .frame     (frame),
    .busy      (busy_l),
    .in_valid  (in_valid_l),
    .in_ready  (in_ready_l),
    .in_data   (in_data),
    .out_valid (out_valid_l),
    .out_ready (out_ready_l),
    .out_data  (out_data_l),
    .done      (done_l),
    .state_dbg (state_dbg_l)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // start is high in cycle 0; after return the bench is in cycle 1
  task automatic do_start();
    cyc   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_expected(input int n);
    logic [DW-1:0] kv [6];
    kv = '{8'h53, 8'h4E, 8'hAA, 8'h58, 8'h2F, 8'hE8};
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(kv[i]);
  endtask

  // records each beat that handshakes at the coming edge
  task automatic collect(input int n, input int budget);
    int k;
    k = 0;
    got_q.delete();
    while (got_q.size() < n && k < budget) begin
      if (out_valid && out_ready) got_q.push_back(out_data);
      tick();
      k++;
    end
    if (got_q.size() < n) check("collect_timeout", 64'(got_q.size()), 64'(n));
  endtask

  task automatic score(input string tag);
    logic [DW-1:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() > 0) check(tag, 64'(got_q.pop_front()), 64'(e));
      else check({tag, "_missing"}, 64'(0), 64'(e));
    end
  endtask

  initial begin
    int n_busy;
    int bad_data;
    int saw_ready;
    logic [DW-1:0] held;

    tests_run   = 0;
    failed      = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    start_l     = 1'b0;
    key         = 64'hEFCDAB8967452312;
    frame       = 22'h134;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    in_valid_l  = 1'b0;
    out_ready_l = 1'b0;

    // reset state
    #12;
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    check("idle_after_release", 64'(state_dbg), 64'd0);

    // timing and known vector
    in_valid  = 1'b1;
    out_ready = 1'b1;
    do_start();
    n_busy = 0;
    while (busy && cyc < 400) begin
      n_busy++;
      tick();
    end
    check("busy_cycles", 64'(n_busy), 64'd186);
    check("run_entry_cycle", 64'(cyc), 64'd187);
    check("run_state", 64'(state_dbg), 64'd4);
    while (!in_ready && cyc < 400) tick();
    check("first_in_ready_cycle", 64'(cyc), 64'd195);
    tick();
    check("first_out_valid", 64'(out_valid), 64'd1);
    check("first_out_valid_cycle", 64'(cyc), 64'd196);
    load_expected(6);
    collect(6, 200);
    score("kv_beat");

    // backpressure on the first beat
    out_ready = 1'b0;
    do_start();
    while (!out_valid && cyc < 400) tick();
    check("bp_first_valid", 64'(out_valid), 64'd1);
    held      = out_data;
    bad_data  = 0;
    saw_ready = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_data !== held || out_valid !== 1'b1) bad_data++;
      if (in_ready) saw_ready++;
    end
    check("bp_data_stable", 64'(bad_data), 64'd0);
    check("bp_in_ready_low", 64'(saw_ready), 64'd0);
    out_ready = 1'b1;
    load_expected(6);
    collect(6, 200);
    score("bp_beat");

    // restart during MIX, then again during RUN
    do_start();
    while (cyc < 120) tick();
    check("mix_at_120", 64'(state_dbg), 64'd3);
    do_start();
    load_expected(6);
    collect(6, 400);
    score("restart_mix_beat");
    check("still_run", 64'(state_dbg), 64'd4);
    do_start();
    load_expected(6);
    collect(6, 400);
    score("restart_run_beat");

    // beat limit on the MAX_BEATS=3 instance
    in_valid_l  = 1'b1;
    out_ready_l = 1'b1;
    start_l     = 1'b1;
    tick();
    start_l = 1'b0;
    got_q.delete();
    for (int k = 0; k < 400 && got_q.size() < 3; k++) begin
      if (out_valid_l && out_ready_l) got_q.push_back(out_data_l);
      tick();
    end
    check("lim_beats", 64'(got_q.size()), 64'd3);
    check("lim_done", 64'(done_l), 64'd1);
    saw_ready = 0;
    for (int i = 0; i < 30; i++) begin
      if (in_ready_l || out_valid_l) saw_ready++;
      tick();
    end
    check("lim_quiet_in_done", 64'(saw_ready), 64'd0);
    check("lim_still_done", 64'(done_l), 64'd1);
    load_expected(3);
    score("lim_beat");
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    check("lim_restart_done", 64'(done_l), 64'd0);
    check("lim_restart_busy", 64'(busy_l), 64'd1);

    // asynchronous reset mid-RUN with a beat held
    out_ready = 1'b0;
    do_start();
    while (!out_valid && cyc < 400) tick();
    check("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd0);
    check("async_state", 64'(state_dbg), 64'd0);
    check("async_lim_busy", 64'(busy_l), 64'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("post_rst_state", 64'(state_dbg), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_out_valid", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
